// File: rtl/user_uart_rx_if.sv
// Request/grant bus between the core and its memory-mapped slaves.
// The slave grants every request in the same cycle; read data follows one cycle later.
interface naive_bus;
    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [31:0] wr_addr;
    logic [3:0]  wr_byte_en;
    logic [31:0] wr_data;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_byte_en, wr_data,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_byte_en, wr_data,
        output rd_gnt, rd_data, wr_gnt
    );
endinterface

// File: rtl/user_uart_rx.sv
// 8N1 UART receiver with 4x oversampling, an RX FIFO and a two-register bus slave
// (DATA at offset 0x0, STATUS at offset 0x4).
module user_uart_rx #(
    parameter int unsigned UART_RX_CLK_DIV = 108,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic    clk,
    input  logic    rstn,
    input  logic    i_uart_rx,
    naive_bus.slave bus
);

    localparam int unsigned DivW = $clog2(UART_RX_CLK_DIV);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    logic            sync_q;
    logic            rxs_q;
    logic [DivW-1:0] div_q;
    logic            tick;

    state_e          state_q;
    logic [1:0]      phase_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            empty;
    logic            full;

    logic            overflow_q;
    logic            frame_err_q;
    logic [31:0]     rd_data_q;

    logic            stop_sample;
    logic            push;
    logic            push_ok;
    logic            frame_set;
    logic            pop;
    logic            status_wr;
    logic [8:0]      count_ext;
    logic [31:0]     status_word;

    assign tick = (div_q == DivW'(UART_RX_CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= 1'b1;
            rxs_q  <= 1'b1;
            div_q  <= '0;
        end else begin
            sync_q <= i_uart_rx;
            rxs_q  <= sync_q;
            div_q  <= tick ? '0 : div_q + 1'b1;
        end
    end

    // Stop-bit decision is shared between the FIFO push and the frame error flag.
    assign stop_sample = tick && (state_q == StStop) && (phase_q == 2'd3);
    assign push        = stop_sample && rxs_q;
    assign frame_set   = stop_sample && !rxs_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rxs_q) begin
                        state_q <= StStart;
                        phase_q <= '0;
                    end
                end
                StStart: begin
                    if (phase_q == 2'd1) begin
                        if (rxs_q) begin
                            state_q <= StIdle;
                        end else begin
                            state_q   <= StData;
                            bit_idx_q <= '0;
                            phase_q   <= '0;
                        end
                    end else begin
                        phase_q <= phase_q + 2'd1;
                    end
                end
                StData: begin
                    if (phase_q == 2'd3) begin
                        shift_q <= {rxs_q, shift_q[7:1]};
                        phase_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        phase_q <= phase_q + 2'd1;
                    end
                end
                StStop: begin
                    if (phase_q == 2'd3) begin
                        phase_q <= '0;
                        state_q <= rxs_q ? StIdle : StBreak;
                    end else begin
                        phase_q <= phase_q + 2'd1;
                    end
                end
                StBreak: begin
                    if (rxs_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign empty     = (count_q == '0);
    assign full      = (count_q == CntW'(FIFO_DEPTH));
    assign push_ok   = push && !full;
    assign pop       = bus.rd_req && !bus.rd_addr[2] && !empty;
    assign status_wr = bus.wr_req && bus.wr_addr[2] && bus.wr_byte_en[0];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(push_ok) - CntW'(pop);
        end
    end

    // A set in the same cycle as a clear wins, so no event is ever lost.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push && full) begin
                overflow_q <= 1'b1;
            end else if (status_wr && bus.wr_data[1]) begin
                overflow_q <= 1'b0;
            end
            if (frame_set) begin
                frame_err_q <= 1'b1;
            end else if (status_wr && bus.wr_data[2]) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    assign count_ext   = 9'(count_q);
    assign status_word = {16'd0, count_ext[7:0], 5'd0, frame_err_q, overflow_q, !empty};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else if (bus.rd_req) begin
            if (bus.rd_addr[2]) begin
                rd_data_q <= status_word;
            end else if (!empty) begin
                rd_data_q <= {1'b1, 23'd0, mem[rd_ptr_q]};
            end else begin
                rd_data_q <= '0;
            end
        end
    end

    assign bus.rd_gnt  = bus.rd_req;
    assign bus.wr_gnt  = bus.wr_req;
    assign bus.rd_data = rd_data_q;

    logic unused_bits;
    assign unused_bits = ^{bus.rd_addr[31:3], bus.rd_addr[1:0], bus.wr_addr[31:3],
                           bus.wr_addr[1:0], bus.wr_byte_en[3:1], bus.wr_data[31:3],
                           bus.wr_data[0], count_ext[8]};

endmodule

// File: tb/tb_user_uart_rx.sv
// Directed and randomized bench for user_uart_rx; expected words come from a
// byte-queue model of the receive FIFO and its sticky flags.
module tb_user_uart_rx;

    localparam int unsigned Div   = 4;
    localparam int unsigned Depth = 16;
    localparam int unsigned Bit   = 4 * Div;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic uart_rx = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    naive_bus bus ();

    user_uart_rx #(
        .UART_RX_CLK_DIV (Div),
        .FIFO_DEPTH      (Depth)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_uart_rx (uart_rx),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #800000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status(input int cnt, input bit fe, input bit ov);
        logic [7:0] c8;
        c8 = 8'(cnt);
        return {16'd0, c8, 5'd0, fe, ov, (cnt != 0)};
    endfunction

    // Callers are at a negedge; each bit lasts Bit clocks.
    task automatic send_byte(input logic [7:0] b, input int stop_low);
        uart_rx = 1'b0;
        repeat (Bit) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (Bit) @(negedge clk);
        end
        if (stop_low > 0) begin
            uart_rx = 1'b0;
            repeat (Bit * stop_low) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (Bit) @(negedge clk);
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr;
        @(negedge clk);
        bus.rd_req  = 1'b0;
        data        = bus.rd_data;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(addr, d);
        check(tag, d, exp);
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        bus.wr_req     = 1'b1;
        bus.wr_addr    = addr;
        bus.wr_byte_en = be;
        bus.wr_data    = data;
        @(negedge clk);
        bus.wr_req     = 1'b0;
    endtask

    logic [7:0]  mq[$];
    bit          m_ov;
    logic [7:0]  b;
    logic [31:0] d;
    int          n;
    int          start_k;
    int          start2;
    int          push_cyc;
    int          target;
    bit          found;

    initial begin
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        bus.wr_req     = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_byte_en = '0;
        bus.wr_data    = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Reset state and combinational grants.
        check("reset_rd_data", bus.rd_data, 32'h0);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 32'h4;
        #1;
        check("rd_gnt", {31'd0, bus.rd_gnt}, 32'h1);
        @(negedge clk);
        bus.rd_req = 1'b0;
        check("reset_status", bus.rd_data, 32'h0);
        bus.wr_req = 1'b1;
        #1;
        check("wr_gnt", {31'd0, bus.wr_gnt}, 32'h1);
        bus.wr_req = 1'b0;
        @(negedge clk);

        // Single byte.
        send_byte(8'h55, 0);
        repeat (4) @(negedge clk);
        rd_chk("single_status", 32'h4, 32'h0000_0101);
        rd_chk("single_data", 32'h0, 32'h8000_0055);
        rd_chk("single_empty", 32'h0, 32'h0);

        // Overflow and ordering.
        for (int i = 0; i < 17; i++) send_byte(8'(i), 0);
        repeat (4) @(negedge clk);
        rd_chk("ovf_status", 32'h4, 32'h0000_1003);
        for (int i = 0; i < 16; i++) rd_chk("ovf_order", 32'h0, 32'h8000_0000 | 32'(i));
        rd_chk("ovf_17th", 32'h0, 32'h0);
        bus_wr(32'h4, 4'b1110, 32'h6);
        rd_chk("ovf_be_gated", 32'h4, 32'h0000_0002);
        bus_wr(32'h0, 4'b1111, 32'h6);
        rd_chk("ovf_data_wr_ignored", 32'h4, 32'h0000_0002);
        bus_wr(32'h4, 4'b0001, 32'h2);
        rd_chk("ovf_cleared", 32'h4, 32'h0);

        // Frame error, then recovery.
        send_byte(8'hA5, 2);
        repeat (2 * Bit) @(negedge clk);
        rd_chk("ferr_status", 32'h4, 32'h0000_0004);
        send_byte(8'h3C, 0);
        repeat (4) @(negedge clk);
        rd_chk("ferr_recover_status", 32'h4, 32'h0000_0105);
        rd_chk("ferr_recover_data", 32'h0, 32'h8000_003C);
        bus_wr(32'h4, 4'b0001, 32'h4);
        rd_chk("ferr_cleared", 32'h4, 32'h0);

        // Glitches shorter than half a bit.
        uart_rx = 1'b0;
        repeat (Div) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * Bit) @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * Bit) @(negedge clk);
        rd_chk("glitch_status", 32'h4, 32'h0);

        // Locate the push cycle of a frame by polling STATUS every cycle.
        found    = 1'b0;
        push_cyc = 0;
        start_k  = cyc;
        fork
            send_byte(8'hA7, 0);
            begin
                repeat (100) @(negedge clk);
                bus.rd_req  = 1'b1;
                bus.rd_addr = 32'h4;
                for (int i = 0; i < 100 && !found; i++) begin
                    @(negedge clk);
                    if (bus.rd_data[15:8] == 8'd1) begin
                        found    = 1'b1;
                        push_cyc = cyc - 2;
                    end
                end
                bus.rd_req = 1'b0;
            end
        join
        check("calib_push_seen", {31'd0, found}, 32'h1);

        // Same frame timing again, with a DATA read on the push cycle.
        for (int i = 0; i < 8 && ((cyc % Div) != (start_k % Div)); i++) @(negedge clk);
        start2 = cyc;
        target = start2 + (push_cyc - start_k);
        d = '0;
        fork
            send_byte(8'hB2, 0);
            begin
                for (int i = 0; i < 400 && cyc != target; i++) @(negedge clk);
                bus_rd(32'h0, d);
            end
        join
        check("simul_read", d, 32'h8000_00A7);
        rd_chk("simul_count", 32'h4, 32'h0000_0101);
        rd_chk("simul_next", 32'h0, 32'h8000_00B2);
        rd_chk("simul_empty", 32'h4, 32'h0);

        // Randomized bursts against the queue model.
        m_ov = 1'b0;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 19);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                send_byte(b, 0);
                repeat ($urandom_range(0, 12)) @(negedge clk);
                if (mq.size() < Depth) mq.push_back(b);
                else m_ov = 1'b1;
            end
            repeat (4) @(negedge clk);
            rd_chk("rand_status", 32'h4, status(mq.size(), 1'b0, m_ov));
            while (mq.size() > 0) rd_chk("rand_data", 32'h0, {1'b1, 23'd0, mq.pop_front()});
            rd_chk("rand_drained", 32'h0, 32'h0);
            bus_wr(32'h4, 4'b0001, 32'h2);
            m_ov = 1'b0;
            rd_chk("rand_cleared", 32'h4, status(0, 1'b0, 1'b0));
        end

        // Reset during data bit 4 of a frame whose tail is all ones.
        send_byte(8'h99, 0);
        repeat (4) @(negedge clk);
        rd_chk("prereset_status", 32'h4, 32'h0000_0101);
        fork
            send_byte(8'hF3, 0);
            begin
                repeat (5 * Bit + Bit / 2) @(negedge clk);
                rstn = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
                check("midreset_rd_data", bus.rd_data, 32'h0);
            end
        join
        repeat (4 * Bit) @(negedge clk);
        rd_chk("midreset_status", 32'h4, 32'h0);
        send_byte(8'h81, 0);
        repeat (4) @(negedge clk);
        rd_chk("postreset_data", 32'h0, 32'h8000_0081);
        rd_chk("postreset_status", 32'h4, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
